// File: rtl/vend_pkg.sv
// Shared types and constants for the soda vending controller slice.
// Machine states are plain 2-bit constants; soda choices are an enum.
package vend_pkg;

  localparam int CLK_HZ       = 100;
  localparam int SODA_PRICE_C = 70;

  typedef logic [1:0] state_t;
  localparam state_t IDLE     = 2'd0;
  localparam state_t WAIT_SEL = 2'd1;
  localparam state_t VEND     = 2'd2;

  typedef enum logic [1:0] {
    SODA_A = 2'd0,
    SODA_B = 2'd1,
    SODA_C = 2'd2
  } soda_t;

  // A wins over B, B over C; only called when at least one press is present.
  function automatic soda_t pick_soda(input logic press_a, input logic press_b);
    if (press_a) return SODA_A;
    else if (press_b) return SODA_B;
    else return SODA_C;
  endfunction

endpackage

// File: rtl/vend_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module vend_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soda_vend_controller.sv
// Soda selection / vend-window controller downstream of the coin accumulator.
// Vend lines, coin_inhibit and busy are registered from the next-state decode.
module soda_vend_controller
  import vend_pkg::*;
#(
  parameter int VEND_CYCLES = CLK_HZ,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             credit_ok,
  input  logic             sel_a,
  input  logic             sel_b,
  input  logic             sel_c,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             coin_inhibit,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
);

  localparam int TW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(VEND_CYCLES - 1);

  state_t        state;
  state_t        next_state;
  soda_t         choice;
  soda_t         next_choice;
  logic [TW-1:0] timer;
  logic          pending;
  logic          sel_a_prev;
  logic          sel_b_prev;
  logic          sel_c_prev;
  logic          press_a;
  logic          press_b;
  logic          press_c;
  logic          any_press;
  logic          timer_done;
  logic          sel_fire;

  assign press_a    = sel_a & ~sel_a_prev;
  assign press_b    = sel_b & ~sel_b_prev;
  assign press_c    = sel_c & ~sel_c_prev;
  assign any_press  = press_a | press_b | press_c;
  assign timer_done = (timer == '0);
  assign sel_fire   = (state == WAIT_SEL) && any_press;

  // A credit pulse on the final vend cycle counts as pending, so no coin is lost.
  always_comb begin
    next_state  = state;
    next_choice = choice;
    case (state)
      IDLE: begin
        if (credit_ok) next_state = WAIT_SEL;
      end
      WAIT_SEL: begin
        if (any_press) begin
          next_state  = VEND;
          next_choice = pick_soda(press_a, press_b);
        end
      end
      VEND: begin
        if (timer_done) next_state = (pending || credit_ok) ? WAIT_SEL : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      choice       <= SODA_A;
      timer        <= '0;
      pending      <= 1'b0;
      sel_a_prev   <= 1'b0;
      sel_b_prev   <= 1'b0;
      sel_c_prev   <= 1'b0;
      a_o          <= 1'b0;
      b_o          <= 1'b0;
      c_o          <= 1'b0;
      coin_inhibit <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state      <= next_state;
      choice     <= next_choice;
      sel_a_prev <= sel_a;
      sel_b_prev <= sel_b;
      sel_c_prev <= sel_c;

      if (sel_fire) begin
        timer <= TIMER_LOAD;
      end else if ((state == VEND) && !timer_done) begin
        timer <= timer - 1'b1;
      end

      if (state == VEND) begin
        pending <= timer_done ? 1'b0 : (pending | credit_ok);
      end else begin
        pending <= 1'b0;
      end

      a_o          <= (next_state == VEND) && (next_choice == SODA_A);
      b_o          <= (next_state == VEND) && (next_choice == SODA_B);
      c_o          <= (next_state == VEND) && (next_choice == SODA_C);
      coin_inhibit <= (next_state == VEND);
      busy         <= (next_state != IDLE);
    end
  end

  logic inc_a;
  logic inc_b;
  logic inc_c;

  assign inc_a = sel_fire & press_a;
  assign inc_b = sel_fire & ~press_a & press_b;
  assign inc_c = sel_fire & ~press_a & ~press_b & press_c;

  vend_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (inc_a),
    .cnt    (cnt_a)
  );

  vend_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (inc_b),
    .cnt    (cnt_b)
  );

  vend_sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (inc_c),
    .cnt    (cnt_c)
  );

endmodule

// File: doc/soda_vend_controller.md
Name: soda_vend_controller

Overview:
- Downstream stage of the coin-accumulator block. It consumes the single-cycle `dispense` (credit reached) pulse and waits for a soda choice: A, B or C.
- It then drives the matching vend line for a fixed window of VEND_CYCLES clocks. At 100 Hz the default of 100 cycles is 1 s.
- It also drives `coin_inhibit` back to the accumulator/coin slots, and keeps saturating per-soda sale counters for the maintenance display.

Parameters:
- VEND_CYCLES, 100, vend line on-time in clocks (1 s at 100 Hz); legal range 1..65535.
- CNT_W, 8, width of each per-soda sale counter.

Ports:
- clk  input  1  system clock (100 Hz).
- reset_n  input  1  asynchronous active-low reset.
- credit_ok  input  1  single-cycle pulse from the accumulator: credit of at least 70c reached.
- sel_a  input  1  level from soda A button, synchronous to clk.
- sel_b  input  1  level from soda B button.
- sel_c  input  1  level from soda C button.
- a_o  output  1  vend line A.
- b_o  output  1  vend line B.
- c_o  output  1  vend line C.
- coin_inhibit  output  1  high means coins must be rejected.
- busy  output  1  high in WAIT_SEL or VEND.
- cnt_a  output  CNT_W  count of A vends, saturating.
- cnt_b  output  CNT_W  count of B vends, saturating.
- cnt_c  output  CNT_W  count of C vends, saturating.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; a_o, b_o, c_o, coin_inhibit and busy = 0.
  - Timer = 0, pending = 0, all counters = 0.
  - Selection edge registers = 0.
  - Reset asserted mid-VEND drops the vend line immediately.
- Selection edge detect:
  - sel_x_prev is registered every cycle.
  - A press is sel_x & ~sel_x_prev, so a held button never re-vends.
  - Priority when several press edges land in one cycle: A > B > C.
- States:
  - IDLE:
    - credit_ok=1 -> WAIT_SEL next cycle.
    - Press edges are ignored.
  - WAIT_SEL:
    - busy=1; coin_inhibit=0 (overpayment is allowed and lost; no change is returned).
    - A press edge -> VEND next cycle. Latch the choice, load timer with VEND_CYCLES-1, increment that soda's counter (saturate at 2^CNT_W-1).
    - credit_ok arriving here is ignored; credit is not stacked.
    - No timeout.
  - VEND:
    - Only the latched line is high, for exactly VEND_CYCLES consecutive cycles starting the cycle after the press edge.
    - coin_inhibit=1 and busy=1.
    - Timer decrements each cycle. At timer==0 leave VEND: go to WAIT_SEL if pending=1, else IDLE.
    - Clear pending on exit.
    - All press edges during VEND are ignored, including edges still present at exit. A button held through the exit does not vend.
- Pending credit:
  - credit_ok=1 during VEND sets pending=1; further pulses are absorbed, max one stored.
  - This covers coins already in flight when the inhibit rose.
- Output timing:
  - Vend lines and coin_inhibit are registered outputs decoded from next-state. They rise the cycle after the press edge and fall the cycle after the final vend cycle.
  - The inhibit is not glitchy.
- Width rules:
  - Timer width is clog2(VEND_CYCLES).
  - Counters never wrap.

Decomposition:
- Shared package vend_pkg holds:
  - state typedef {IDLE, WAIT_SEL, VEND};
  - soda choice typedef {SODA_A, SODA_B, SODA_C};
  - constants CLK_HZ=100 and SODA_PRICE_C=70.
- One natural sub-module: vend_sat_counter, a CNT_W-bit saturating incrementer with enable, instantiated three times.
- The FSM, timer and edge detect stay in the top module.

Test Plan:
- Basic vend: reset, credit_ok pulse, then sel_b rises 3 cycles later.
  - b_o is high for exactly 100 cycles; coin_inhibit is high for the same 100 cycles.
  - cnt_b=1; state returns to IDLE and busy=0.
- Held and simultaneous buttons:
  - sel_a held high from before credit_ok: no vend until the button is released and pressed again.
  - sel_a and sel_c rising in the same cycle: only a_o is high; cnt_a increments, cnt_c stays 0.
- Pending credit:
  - credit_ok pulses twice during VEND: after c_o falls, the state is WAIT_SEL (busy=1, coin_inhibit=0).
  - Exactly one more vend is possible, then IDLE.
- Asynchronous reset mid-vend:
  - Assert reset_n=0 at cycle 40 of VEND, off the clock edge: a_o and coin_inhibit drop immediately and counters clear.
  - After release, the state is IDLE and no vend line is high.
- Saturation:
  - 260 complete A vends (run with VEND_CYCLES=2 for speed): cnt_a holds 255; cnt_b and cnt_c stay 0.
- Presses ignored outside WAIT_SEL:
  - sel_c edges in IDLE with no credit: no vend line rises and counters do not change.
  - sel_c edges during a vend: that vend's 100 cycles are unchanged and the choice is not altered.
